// File: rtl/probe_capture.sv
// probe_capture: transparent debug probe with a circular capture buffer.
//
// IN is passed straight to OUT. On EN_arm the block starts recording IN
// every cycle into a depth-entry ring. A masked match of IN against
// MATCH_VAL freezes the capture after posttrig further samples. The
// captured window is then read out oldest-first through RDY_rd/EN_rd.
//
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   IN / OUT              probed signal and its combinational copy
//   MATCH_VAL, MATCH_MASK trigger compare value and mask (1 = compared)
//   EN_arm / RDY_arm      start a capture (accepted in IDLE and DONE)
//   EN_rd / RDY_rd        pop one readout sample (valid in DONE)
//   RD_DATA, RD_LAST      current readout sample and last-sample flag
//   TRIG_IDX              readout position of the trigger sample
//   STAMP                 cycles from arm to trigger, saturating
//   STATE                 0 IDLE, 1 ARMED, 2 POST, 3 DONE
module probe_capture #(
  parameter int size     = 32,
  parameter int depth    = 16,
  parameter int logdepth = 4,
  parameter int posttrig = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [size-1:0]     IN,
  output logic [size-1:0]     OUT,
  input  logic [size-1:0]     MATCH_VAL,
  input  logic [size-1:0]     MATCH_MASK,
  input  logic                EN_arm,
  output logic                RDY_arm,
  input  logic                EN_rd,
  output logic                RDY_rd,
  output logic [size-1:0]     RD_DATA,
  output logic                RD_LAST,
  output logic [logdepth-1:0] TRIG_IDX,
  output logic [15:0]         STAMP,
  output logic [1:0]          STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [logdepth:0]   DEPTH_N = (logdepth + 1)'(depth);
  localparam logic [logdepth-1:0] PT      = logdepth'(posttrig);

  state_t              state, state_next;
  logic [logdepth-1:0] wptr;
  logic [logdepth:0]   count;
  logic [logdepth-1:0] remain;
  logic [logdepth-1:0] rptr;
  logic [logdepth:0]   rcnt;
  logic [logdepth-1:0] trig_idx;
  logic [15:0]         stamp;

  logic [size-1:0]     mem [depth];

  logic                hit;
  logic                capturing;
  logic                arm_go;
  logic                pop;
  logic                done_entry;
  logic [logdepth-1:0] wptr_inc;
  logic [logdepth:0]   count_next;

  // The probed path never depends on state or reset.
  assign OUT = IN;

  assign hit        = ((IN ^ MATCH_VAL) & MATCH_MASK) == '0;
  assign capturing  = (state == S_ARMED) || (state == S_POST);
  assign RDY_arm    = (state == S_IDLE) || (state == S_DONE);
  assign RDY_rd     = (state == S_DONE) && (rcnt != '0);
  assign arm_go     = EN_arm && RDY_arm;
  // Arm wins over a simultaneous pop.
  assign pop        = EN_rd && RDY_rd && !arm_go;
  assign wptr_inc   = wptr + logdepth'(1);
  assign count_next = (count == DEPTH_N) ? count : count + (logdepth + 1)'(1);
  assign done_entry = (state == S_ARMED && hit && posttrig == 0) ||
                      (state == S_POST && remain == logdepth'(1));

  assign RD_DATA  = RDY_rd ? mem[rptr] : '0;
  assign RD_LAST  = RDY_rd && (rcnt == (logdepth + 1)'(1));
  assign TRIG_IDX = trig_idx;
  assign STAMP    = stamp;
  assign STATE    = state;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (EN_arm) state_next = S_ARMED;
      S_ARMED: if (hit) state_next = (posttrig == 0) ? S_DONE : S_POST;
      S_POST:  if (remain == logdepth'(1)) state_next = S_DONE;
      S_DONE: begin
        if (EN_arm)
          state_next = S_ARMED;
        else if (pop && rcnt == (logdepth + 1)'(1))
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr     <= '0;
      count    <= '0;
      remain   <= '0;
      rptr     <= '0;
      rcnt     <= '0;
      trig_idx <= '0;
      stamp    <= '0;
    end else if (arm_go) begin
      wptr     <= '0;
      count    <= '0;
      rcnt     <= '0;
      trig_idx <= '0;
      stamp    <= '0;
    end else if (capturing) begin
      wptr  <= wptr_inc;
      count <= count_next;
      if (state == S_ARMED) begin
        if (hit)
          remain <= PT;
        else if (stamp != 16'hFFFF)
          stamp <= stamp + 16'd1;
      end else begin
        remain <= remain - logdepth'(1);
      end
      // The window ends at the sample written this cycle; the oldest valid
      // entry sits nvalid slots behind the post-write pointer.
      if (done_entry) begin
        rptr     <= wptr_inc - count_next[logdepth-1:0];
        rcnt     <= count_next;
        trig_idx <= count_next[logdepth-1:0] - logdepth'(1) - PT;
      end
    end else if (pop) begin
      rptr <= rptr + logdepth'(1);
      rcnt <= rcnt - (logdepth + 1)'(1);
    end
  end

  // Capture storage is data only and is never cleared; RD_DATA masks it.
  always_ff @(posedge CLK) begin
    if (capturing) mem[wptr] <= IN;
  end

endmodule

// File: tb/tb_probe_capture.sv
module tb_probe_capture;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] in_v, mval, mmask;
  logic        en_arm, en_rd, sel;

  always #5 CLK = ~CLK;

  logic [31:0] out_a, out_b, rd_data_a, rd_data_b;
  logic        rdy_arm_a, rdy_arm_b, rdy_rd_a, rdy_rd_b, rd_last_a, rd_last_b;
  logic [3:0]  trig_idx_a, trig_idx_b;
  logic [15:0] stamp_a, stamp_b;
  logic [1:0]  state_a, state_b;

  // Instance a: default parameters. Instance b: posttrig = 0.
  probe_capture u_a (
    .CLK(CLK), .RST_N(RST_N), .IN(in_v), .OUT(out_a),
    .MATCH_VAL(mval), .MATCH_MASK(mmask),
    .EN_arm(en_arm & ~sel), .RDY_arm(rdy_arm_a),
    .EN_rd(en_rd & ~sel), .RDY_rd(rdy_rd_a),
    .RD_DATA(rd_data_a), .RD_LAST(rd_last_a),
    .TRIG_IDX(trig_idx_a), .STAMP(stamp_a), .STATE(state_a)
  );

  probe_capture #(.posttrig(0)) u_b (
    .CLK(CLK), .RST_N(RST_N), .IN(in_v), .OUT(out_b),
    .MATCH_VAL(mval), .MATCH_MASK(mmask),
    .EN_arm(en_arm & sel), .RDY_arm(rdy_arm_b),
    .EN_rd(en_rd & sel), .RDY_rd(rdy_rd_b),
    .RD_DATA(rd_data_b), .RD_LAST(rd_last_b),
    .TRIG_IDX(trig_idx_b), .STAMP(stamp_b), .STATE(state_b)
  );

  logic [31:0] o_out, o_rd_data;
  logic        o_rdy_arm, o_rdy_rd, o_rd_last;
  logic [3:0]  o_trig_idx;
  logic [15:0] o_stamp;
  logic [1:0]  o_state;

  assign o_out      = sel ? out_b      : out_a;
  assign o_rd_data  = sel ? rd_data_b  : rd_data_a;
  assign o_rdy_arm  = sel ? rdy_arm_b  : rdy_arm_a;
  assign o_rdy_rd   = sel ? rdy_rd_b   : rdy_rd_a;
  assign o_rd_last  = sel ? rd_last_b  : rd_last_a;
  assign o_trig_idx = sel ? trig_idx_b : trig_idx_a;
  assign o_stamp    = sel ? stamp_b    : stamp_a;
  assign o_state    = sel ? state_b    : state_a;

  int checks = 0;
  int errors = 0;

  // Reference model state: every sample captured since the last arm, and
  // the index of the first trigger hit among them (-1 if none yet).
  logic [31:0] hist[$];
  int          k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit is_hit(input logic [31:0] v);
    return ((v ^ mval) & mmask) == 32'd0;
  endfunction

  task automatic do_arm(input bit with_rd);
    en_arm = 1'b1;
    en_rd  = with_rd;
    step();
    en_arm = 1'b0;
    en_rd  = 1'b0;
    chk("arm_state", {30'd0, o_state}, 32'd1);
    chk("arm_rdy_rd", {31'd0, o_rdy_rd}, 32'd0);
    chk("arm_rdy_arm", {31'd0, o_rdy_arm}, 32'd0);
    chk("arm_stamp", {16'd0, o_stamp}, 32'd0);
  endtask

  // mode 0: IN counts 1,2,3,...; mode 1: random with a forced hit at trig_at.
  task automatic do_capture(input int pt, input int mode, input int trig_at,
                            input bit abort_post);
    bit          done;
    int          exp_st;
    logic [31:0] v;
    done = 1'b0;
    hist.delete();
    k = -1;
    for (int g = 0; g < 400 && !done; g++) begin
      if (mode == 0) begin
        v = hist.size() + 1;
      end else begin
        v = $urandom;
        if (hist.size() == trig_at) v = (mval & mmask) | (v & ~mmask);
      end
      in_v = v;
      step();
      hist.push_back(v);
      if (k < 0 && is_hit(v)) k = hist.size() - 1;
      if (k >= 0 && hist.size() == k + 1 + pt) exp_st = 3;
      else if (k >= 0) exp_st = 2;
      else exp_st = 1;
      chk("capture_state", {30'd0, o_state}, exp_st);
      chk("out_passthru", o_out, v);
      if (exp_st == 3) done = 1'b1;
      if (abort_post && exp_st == 2) return;
    end
    chk("capture_timeout", {31'd0, done}, 32'd1);
  endtask

  // Reads the window oldest-first; stops before pop number stop_after if >= 0.
  task automatic do_readout(input int pt, input int stop_after);
    int nvalid, base;
    nvalid = (hist.size() > 16) ? 16 : hist.size();
    base   = hist.size() - nvalid;
    chk("done_trig_idx", {28'd0, o_trig_idx}, (nvalid - 1 - pt) & 15);
    chk("done_stamp", {16'd0, o_stamp}, (k > 65535) ? 65535 : k);
    chk("done_rdy_arm", {31'd0, o_rdy_arm}, 32'd1);
    for (int i = 0; i < nvalid; i++) begin
      if (stop_after >= 0 && i == stop_after) return;
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("stall_state", {30'd0, o_state}, 32'd3);
      end
      chk("rd_rdy", {31'd0, o_rdy_rd}, 32'd1);
      chk("rd_data", o_rd_data, hist[base + i]);
      chk("rd_last", {31'd0, o_rd_last}, (i == nvalid - 1) ? 32'd1 : 32'd0);
      en_rd = 1'b1;
      step();
      en_rd = 1'b0;
    end
    chk("post_rd_state", {30'd0, o_state}, 32'd0);
    chk("post_rd_rdy_rd", {31'd0, o_rdy_rd}, 32'd0);
    chk("post_rd_data", o_rd_data, 32'd0);
    chk("post_rd_rdy_arm", {31'd0, o_rdy_arm}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel    = 1'b0;
    en_arm = 1'b0;
    en_rd  = 1'b0;
    mval   = 32'd0;
    mmask  = 32'hFFFF_FFFF;
    in_v   = 32'hA5A5_0000;
    RST_N  = 1'b0;
    k      = -1;
    step();
    step();
    RST_N = 1'b1;
    step();

    // Reset state
    chk("rst_out", o_out, 32'hA5A5_0000);
    chk("rst_state", {30'd0, o_state}, 32'd0);
    chk("rst_rdy_arm", {31'd0, o_rdy_arm}, 32'd1);
    chk("rst_rdy_rd", {31'd0, o_rdy_rd}, 32'd0);
    chk("rst_rd_data", o_rd_data, 32'd0);
    chk("rst_state_b", {30'd0, state_b}, 32'd0);

    // Counting input, trigger on 20: window 13..28, TRIG_IDX 7, STAMP 19
    mval = 32'd20;
    do_arm(1'b0);
    do_capture(8, 0, 0, 1'b0);
    chk("t1_len", hist.size(), 28);
    chk("t1_trig_idx", {28'd0, o_trig_idx}, 32'd7);
    chk("t1_stamp", {16'd0, o_stamp}, 32'd19);
    do_readout(8, -1);

    // Trigger on third sample: 11 samples, TRIG_IDX 2, STAMP 2
    mval = 32'd3;
    do_arm(1'b0);
    do_capture(8, 0, 0, 1'b0);
    chk("t2_trig_idx", {28'd0, o_trig_idx}, 32'd2);
    chk("t2_stamp", {16'd0, o_stamp}, 32'd2);
    do_readout(8, -1);

    // All-zero mask, posttrig 0: single sample
    sel   = 1'b1;
    mmask = 32'd0;
    do_arm(1'b0);
    do_capture(0, 1, 0, 1'b0);
    chk("t3_len", hist.size(), 1);
    chk("t3_rd_last", {31'd0, o_rd_last}, 32'd1);
    chk("t3_trig_idx", {28'd0, o_trig_idx}, 32'd0);
    do_readout(0, -1);

    // Pop 3, then arm together with a pop: arm wins
    sel   = 1'b0;
    mval  = $urandom;
    mmask = 32'hFFFF_FFFF;
    do_arm(1'b0);
    do_capture(8, 1, 12, 1'b0);
    do_readout(8, 3);
    do_arm(1'b1);
    do_capture(8, 1, 5, 1'b0);
    do_readout(8, -1);

    // Asynchronous reset during POST
    do_arm(1'b0);
    do_capture(8, 1, 4, 1'b1);
    chk("pre_rst_state", {30'd0, o_state}, 32'd2);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_state", {30'd0, o_state}, 32'd0);
    chk("arst_rdy_arm", {31'd0, o_rdy_arm}, 32'd1);
    chk("arst_rdy_rd", {31'd0, o_rdy_rd}, 32'd0);
    chk("arst_rd_data", o_rd_data, 32'd0);
    chk("arst_rd_last", {31'd0, o_rd_last}, 32'd0);
    chk("arst_trig_idx", {28'd0, o_trig_idx}, 32'd0);
    chk("arst_stamp", {16'd0, o_stamp}, 32'd0);
    chk("arst_out", o_out, in_v);
    step();
    RST_N = 1'b1;
    step();
    do_arm(1'b0);
    do_capture(8, 1, 20, 1'b0);
    do_readout(8, -1);

    // Randomised captures on both instances
    for (int r = 0; r < 8; r++) begin
      sel   = r[0];
      mval  = $urandom;
      mmask = $urandom | 32'hFFF0_0000;
      do_arm(1'b0);
      do_capture(sel ? 0 : 8, 1, $urandom_range(0, 40), 1'b0);
      do_readout(sel ? 0 : 8, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/probe_capture.md
# probe_capture

Parametrised debug probe that passes a `size`-bit signal straight through, like a plain probe wire, and also records it into a circular capture buffer. Capture stops on a masked-match trigger after a programmable number of post-trigger samples. The captured window is read out oldest-first through a ready/enable handshake. It sits beside any internal bus the team wants to observe in silicon, with no effect on the probed path.

## Interface
Parameters:
- size, 32, probed signal width in bits (1..256)
- depth, 16, capture buffer entries; power of two, at least 2
- logdepth, 4, log2(depth)
- posttrig, 8, samples stored after the trigger sample; 0..depth-1

Ports:
- CLK  in  1  sole clock; all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- IN  in  size  probed signal
- OUT  out  size  equals IN, purely combinational; unaffected by reset or state
- MATCH_VAL  in  size  trigger compare value
- MATCH_MASK  in  size  trigger compare mask (1 = bit compared)
- EN_arm  in  1  start a capture; honoured only when RDY_arm=1
- RDY_arm  out  1  high in IDLE and DONE
- EN_rd  in  1  pop one readout sample; honoured only when RDY_rd=1
- RDY_rd  out  1  high in DONE while unread samples remain
- RD_DATA  out  size  current readout sample; 0 when RDY_rd=0
- RD_LAST  out  1  high with RDY_rd when RD_DATA is the final sample
- TRIG_IDX  out  logdepth  readout position (0 = oldest) of the trigger sample
- STAMP  out  16  cycles from arm to trigger, saturating at 16'hFFFF
- STATE  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE

## Operation
- Trigger hit: ((IN ^ MATCH_VAL) & MATCH_MASK) == 0. An all-zero MATCH_MASK hits on every cycle.
- IDLE:
  - Nothing is written.
  - EN_arm clears wptr, count and STAMP, then goes to ARMED.
- ARMED, every cycle:
  - Write IN to buf[wptr]. wptr increments mod depth. count increments, saturating at depth.
  - No hit: STAMP increments, saturating.
  - Hit with posttrig=0: go to DONE.
  - Hit with posttrig>0: go to POST and load remain=posttrig.
  - The hit sample is always written.
- POST, every cycle:
  - Write as in ARMED and decrement remain.
  - When remain reaches 0 on this cycle's write, go to DONE.
  - Further hits are ignored.
- Entry to DONE:
  - nvalid = count after the final write.
  - rptr = (wptr - nvalid) mod depth.
  - rcnt = nvalid.
  - TRIG_IDX = nvalid-1-posttrig. If the trigger sample was overwritten (nvalid-1 < posttrig is impossible by the parameter bound), the value is still well-defined.
- DONE:
  - RDY_rd = (rcnt != 0).
  - RD_DATA = buf[rptr].
  - RD_LAST = (rcnt == 1).
  - EN_rd&&RDY_rd increments rptr mod depth and decrements rcnt. The pop that takes rcnt to 0 returns to IDLE.
  - EN_arm in DONE abandons the readout and re-arms, exactly as from IDLE. If EN_arm and EN_rd arrive together, arm wins.
- EN_arm in ARMED/POST and EN_rd outside DONE are ignored.
- TRIG_IDX and STAMP hold until the next arm.
- Reset mid-capture or mid-readout: immediate return to reset values. Buffer contents are not cleared and are never visible, because RD_DATA is forced to 0.

## Timing
- Reset values:
  - STATE=0, RDY_arm=1, RDY_rd=0, RD_DATA=0, RD_LAST=0, TRIG_IDX=0, STAMP=0.
  - OUT follows IN.
- Arm latency: STATE=1 on the cycle after EN_arm. The first sample is IN on that cycle; the arm cycle itself is not captured.
- Trigger in cycle t: STATE=3 in cycle t+1+posttrig. The last sample written is at cycle t+posttrig.
- The buffer read is combinational from registered rptr, so RD_DATA is valid in the same cycle RDY_rd rises. A pop takes effect at the following edge.
- Full readout takes nvalid cycles at one pop per cycle. The cycle after the last pop shows STATE=0.
- wptr/rptr wrap modulo depth. count never exceeds depth.

## Test plan
- Reset, then IN=32'hA5A5_0000 -> OUT=32'hA5A5_0000, STATE=0, RDY_arm=1, RDY_rd=0, RD_DATA=0.
- Default params, arm, IN counts 1,2,3,... from the first ARMED cycle, MATCH_VAL=20, MASK=all-ones -> STATE=3 after sample 28; readout yields 13..28 with RD_LAST on 28; TRIG_IDX=7; STAMP=19; then STATE=0.
- Trigger at the third ARMED sample (IN=3, posttrig=8) -> nvalid=11, readout 1..11, TRIG_IDX=2, STAMP=2.
- MATCH_MASK=0, posttrig=0 -> DONE two cycles after EN_arm; single sample; RD_LAST=1; TRIG_IDX=0; STAMP=0.
- In DONE, pop 3 samples, then assert EN_arm together with EN_rd -> arm wins; STATE=1 next cycle; RDY_rd=0; STAMP=0.
- Deassert RST_N asynchronously during POST -> all outputs at reset values without waiting for CLK; the next arm captures normally.
